// File: rtl/vga_frame_buffer_ctrl.sv
// Bus-mapped 160x120 one-bit frame buffer with hardware clear, feeding the VGA generator.
// Optional cursor auto-increment on pixel writes: define VGA_FB_AUTOINC_EN.
module vga_frame_buffer_ctrl #(
   parameter logic [7:0] BASE_ADDR = 8'hB0,
   parameter logic [7:0] X_MAX     = 8'd159,
   parameter logic [6:0] Y_MAX     = 7'd119
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  BUS_ADDR,
   input  logic [7:0]  BUS_DATA_IN,
   input  logic        BUS_WE,
   output logic [7:0]  BUS_DATA_OUT,
   output logic        BUS_DATA_OE,
   input  logic [14:0] VGA_ADDR,
   output logic        VGA_DATA,
   output logic [15:0] CONFIG_COLOURS,
   output logic        BUSY
);

   localparam logic [2:0] REG_X    = 3'd0;
   localparam logic [2:0] REG_Y    = 3'd1;
   localparam logic [2:0] REG_PIX  = 3'd2;
   localparam logic [2:0] REG_FG   = 3'd3;
   localparam logic [2:0] REG_BG   = 3'd4;
   localparam logic [2:0] REG_CTRL = 3'd5;
   localparam logic [2:0] REG_STAT = 3'd6;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   state_e      state_q;
   logic        busy_q;
   logic [7:0]  cx_q;
   logic [6:0]  cy_q;
   logic        fill_q;

   logic [7:0]  x_q, x_d;
   logic [6:0]  y_q, y_d;
   logic [7:0]  fg_q, fg_d;
   logic [7:0]  bg_q, bg_d;
   logic [7:0]  bus_data_out_q;
   logic        bus_data_oe_q;
   logic        vga_data_q;

   logic        mem_q [0:32767];

   logic [7:0]  offset_s;
   logic        in_win_s;
   logic        wr_s;
   logic        rd_s;
   logic [2:0]  sel_s;
   logic        pix_we_s;
   logic        start_s;
   logic [7:0]  rd_data_s;
   logic        mem_we_s;
   logic [14:0] mem_waddr_s;
   logic        mem_wdata_s;

`ifdef VGA_FB_AUTOINC_EN
   function automatic logic [14:0] cursor_advance(input logic [6:0] y, input logic [7:0] x);
      logic [14:0] r;
      if (x == X_MAX) begin
         r = (y == Y_MAX) ? 15'd0 : {y + 7'd1, 8'd0};
      end else begin
         r = {y, x + 8'd1};
      end
      return r;
   endfunction
`endif

   // Address decode of the 7-byte register window.
   always_comb begin
      offset_s = BUS_ADDR - BASE_ADDR;
      in_win_s = (offset_s < 8'd7);
      wr_s     = in_win_s & BUS_WE;
      rd_s     = in_win_s & ~BUS_WE;
      sel_s    = offset_s[2:0];
   end

   // Next-state of the processor-visible registers and bus-side strobes.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      fg_d     = fg_q;
      bg_d     = bg_q;
      pix_we_s = 1'b0;
      start_s  = 1'b0;
      if (wr_s) begin
         case (sel_s)
            REG_X:    x_d = BUS_DATA_IN;
            REG_Y:    y_d = BUS_DATA_IN[6:0];
            REG_PIX: begin
               pix_we_s = ~busy_q;
`ifdef VGA_FB_AUTOINC_EN
               {y_d, x_d} = busy_q ? {y_q, x_q} : cursor_advance(y_q, x_q);
`endif
            end
            REG_FG:   fg_d = BUS_DATA_IN;
            REG_BG:   bg_d = BUS_DATA_IN;
            REG_CTRL: start_s = BUS_DATA_IN[0] & ~busy_q;
            default:  start_s = 1'b0;
         endcase
      end else begin
         start_s = 1'b0;
      end
   end

   // Read mux; pixel reads are masked to zero while the clear engine owns the memory.
   always_comb begin
      rd_data_s = 8'h00;
      case (sel_s)
         REG_X:    rd_data_s = x_q;
         REG_Y:    rd_data_s = {1'b0, y_q};
         REG_PIX:  rd_data_s = {7'b0000000, mem_q[{y_q, x_q}] & ~busy_q};
         REG_FG:   rd_data_s = fg_q;
         REG_BG:   rd_data_s = bg_q;
         REG_STAT: rd_data_s = {7'b0000000, busy_q};
         default:  rd_data_s = 8'h00;
      endcase
   end

   // Single memory write port shared by the clear engine and bus pixel writes.
   always_comb begin
      mem_we_s    = busy_q | pix_we_s;
      mem_waddr_s = busy_q ? {cy_q, cx_q} : {y_q, x_q};
      mem_wdata_s = busy_q ? fill_q : BUS_DATA_IN[0];
   end

   // Clear engine: one fill write per cycle over the visible area, row by row.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         cx_q    <= 8'd0;
         cy_q    <= 7'd0;
         fill_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
                  cx_q    <= 8'd0;
                  cy_q    <= 7'd0;
                  fill_q  <= BUS_DATA_IN[1];
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (cx_q == X_MAX) begin
                  cx_q <= 8'd0;
                  if (cy_q == Y_MAX) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     cy_q    <= 7'd0;
                  end else begin
                     cy_q <= cy_q + 7'd1;
                  end
               end else begin
                  cx_q <= cx_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Frame store; contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Cursor, colour and registered output stage; VGA read is read-first against same-edge writes.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         x_q            <= 8'd0;
         y_q            <= 7'd0;
         fg_q           <= 8'hFF;
         bg_q           <= 8'h00;
         bus_data_out_q <= 8'h00;
         bus_data_oe_q  <= 1'b0;
         vga_data_q     <= 1'b0;
      end else begin
         x_q            <= x_d;
         y_q            <= y_d;
         fg_q           <= fg_d;
         bg_q           <= bg_d;
         bus_data_out_q <= rd_s ? rd_data_s : 8'h00;
         bus_data_oe_q  <= rd_s;
         vga_data_q     <= mem_q[VGA_ADDR];
      end
   end

   assign BUS_DATA_OUT   = bus_data_out_q;
   assign BUS_DATA_OE    = bus_data_oe_q;
   assign VGA_DATA       = vga_data_q;
   assign CONFIG_COLOURS = {bg_q, fg_q};
   assign BUSY           = busy_q;

endmodule

// File: tb/tb_vga_frame_buffer_ctrl.sv
// Directed self-checking bench for vga_frame_buffer_ctrl (honours VGA_FB_AUTOINC_EN when defined).
module tb_vga_frame_buffer_ctrl;

   localparam logic [7:0] BASE      = 8'hB0;
   localparam logic [7:0] IDLE_ADDR = 8'h00;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  BUS_ADDR;
   logic [7:0]  BUS_DATA_IN;
   logic        BUS_WE;
   logic [7:0]  BUS_DATA_OUT;
   logic        BUS_DATA_OE;
   logic [14:0] VGA_ADDR;
   logic        VGA_DATA;
   logic [15:0] CONFIG_COLOURS;
   logic        BUSY;

   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;

   vga_frame_buffer_ctrl dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .BUS_ADDR       (BUS_ADDR),
      .BUS_DATA_IN    (BUS_DATA_IN),
      .BUS_WE         (BUS_WE),
      .BUS_DATA_OUT   (BUS_DATA_OUT),
      .BUS_DATA_OE    (BUS_DATA_OE),
      .VGA_ADDR       (VGA_ADDR),
      .VGA_DATA       (VGA_DATA),
      .CONFIG_COLOURS (CONFIG_COLOURS),
      .BUSY           (BUSY)
   );

   always #5 CLK = ~CLK;

   // Counts rising edges at which BUSY was high just before the edge.
   always @(posedge CLK) begin
      if (BUSY === 1'b1) busy_cnt++;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
      @(negedge CLK);
      BUS_ADDR    = BASE + {5'd0, off};
      BUS_DATA_IN = d;
      BUS_WE      = 1'b1;
      @(negedge CLK);
      BUS_WE      = 1'b0;
      BUS_ADDR    = IDLE_ADDR;
   endtask

   task automatic bus_read_raw(input logic [7:0] a, output logic [7:0] d, output logic oe);
      @(negedge CLK);
      BUS_ADDR = a;
      BUS_WE   = 1'b0;
      @(negedge CLK);
      d        = BUS_DATA_OUT;
      oe       = BUS_DATA_OE;
      BUS_ADDR = IDLE_ADDR;
   endtask

   task automatic read_check(input string tag, input logic [2:0] off, input logic [7:0] exp);
      logic [7:0] d;
      logic       oe;
      bus_read_raw(BASE + {5'd0, off}, d, oe);
      check(tag, {8'h00, d}, {8'h00, exp});
      check({tag, "_oe"}, {15'd0, oe}, 16'h0001);
   endtask

   task automatic set_xy(input logic [7:0] x, input logic [7:0] y);
      bus_write(3'd0, x);
      bus_write(3'd1, y);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (BUSY === 1'b1 && n < 20500) begin
         @(negedge CLK);
         n++;
      end
      check(tag, {15'd0, BUSY}, 16'h0000);
   endtask

   initial begin
      logic [7:0] d;
      logic       oe;
      int         b0;

      RESET       = 1'b0;
      BUS_ADDR    = IDLE_ADDR;
      BUS_DATA_IN = 8'h00;
      BUS_WE      = 1'b0;
      VGA_ADDR    = 15'h0000;
      repeat (3) @(negedge CLK);
      check("rst_colours", CONFIG_COLOURS, 16'h00FF);
      check("rst_busy", {15'd0, BUSY}, 16'h0000);
      check("rst_oe", {15'd0, BUS_DATA_OE}, 16'h0000);
      check("rst_dout", {8'h00, BUS_DATA_OUT}, 16'h0000);
      check("rst_vga", {15'd0, VGA_DATA}, 16'h0000);
      RESET = 1'b1;

      read_check("rst_x", 3'd0, 8'h00);
      @(negedge CLK);
      check("oe_idle", {15'd0, BUS_DATA_OE}, 16'h0000);

      bus_write(3'd3, 8'hE0);
      bus_write(3'd4, 8'h1C);
      check("colours", CONFIG_COLOURS, 16'h1CE0);
      read_check("fg_rd", 3'd3, 8'hE0);
      read_check("bg_rd", 3'd4, 8'h1C);

      bus_write(3'd1, 8'hFF);
      read_check("y_mask", 3'd1, 8'h7F);
      read_check("ctrl_rd", 3'd5, 8'h00);
      read_check("stat_idle", 3'd6, 8'h00);
      bus_read_raw(BASE + 8'd7, d, oe);
      check("win_hi_oe", {15'd0, oe}, 16'h0000);
      bus_read_raw(BASE - 8'd1, d, oe);
      check("win_lo_oe", {15'd0, oe}, 16'h0000);

      set_xy(8'd5, 8'd3);
      bus_write(3'd2, 8'h01);
      set_xy(8'd5, 8'd3);
      read_check("pix_53", 3'd2, 8'h01);
      VGA_ADDR = 15'h0305;
      @(negedge CLK);
      check("vga_53", {15'd0, VGA_DATA}, 16'h0001);

      set_xy(8'd7, 8'd2);
      bus_write(3'd2, 8'h01);
      set_xy(8'd7, 8'd2);
      VGA_ADDR = 15'h0207;
      bus_write(3'd2, 8'h00);
      check("vga_read_first", {15'd0, VGA_DATA}, 16'h0001);
      @(negedge CLK);
      check("vga_after_wr", {15'd0, VGA_DATA}, 16'h0000);

      set_xy(8'd160, 8'd0);
      bus_write(3'd2, 8'h00);
      set_xy(8'd160, 8'd0);
      read_check("pix_oor", 3'd2, 8'h00);

      set_xy(8'd10, 8'd10);
      bus_write(3'd2, 8'h01);
`ifdef VGA_FB_AUTOINC_EN
      read_check("inc_x", 3'd0, 8'h0B);
      set_xy(8'd159, 8'd119);
      bus_write(3'd2, 8'h01);
      read_check("inc_wrap_x", 3'd0, 8'h00);
      read_check("inc_wrap_y", 3'd1, 8'h00);
      set_xy(8'd159, 8'd4);
      bus_write(3'd2, 8'h01);
      read_check("inc_row_x", 3'd0, 8'h00);
      read_check("inc_row_y", 3'd1, 8'h05);
`else
      read_check("noinc_x", 3'd0, 8'h0A);
      read_check("noinc_y", 3'd1, 8'h0A);
`endif

      // Full clear to 1 with dropped pixel write and ignored restart.
      set_xy(8'd5, 8'd3);
      b0 = busy_cnt;
      bus_write(3'd5, 8'h03);
      check("clr_busy", {15'd0, BUSY}, 16'h0001);
      read_check("clr_stat", 3'd6, 8'h01);
      read_check("clr_pix_rd", 3'd2, 8'h00);
      bus_write(3'd2, 8'h00);
      bus_write(3'd5, 8'h01);
      bus_write(3'd0, 8'h05);
      read_check("clr_cursor", 3'd0, 8'h05);
      wait_idle("clr_done");
      check("clr_len", 16'(busy_cnt - b0), 16'd19200);
      set_xy(8'd0, 8'd0);
      read_check("clr_00", 3'd2, 8'h01);
      set_xy(8'd159, 8'd119);
      read_check("clr_last", 3'd2, 8'h01);
      set_xy(8'd5, 8'd3);
      read_check("clr_53", 3'd2, 8'h01);
      set_xy(8'd160, 8'd0);
      read_check("clr_oor", 3'd2, 8'h00);
      read_check("clr_stat_idle", 3'd6, 8'h00);

      // Reset aborts a clear to 0 part-way through.
      bus_write(3'd5, 8'h01);
      repeat (100) @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("abort_busy", {15'd0, BUSY}, 16'h0000);
      @(negedge CLK);
      RESET = 1'b1;
      check("abort_colours", CONFIG_COLOURS, 16'h00FF);
      set_xy(8'd0, 8'd0);
      read_check("abort_00", 3'd2, 8'h00);
      set_xy(8'd159, 8'd119);
      read_check("abort_last", 3'd2, 8'h01);

      b0 = busy_cnt;
      bus_write(3'd5, 8'h01);
      check("reclr_busy", {15'd0, BUSY}, 16'h0001);
      wait_idle("reclr_done");
      check("reclr_len", 16'(busy_cnt - b0), 16'd19200);
      set_xy(8'd159, 8'd119);
      read_check("reclr_last", 3'd2, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
